// File: rtl/var_state_loader.sv
// Moves NUM_VARS variable-state words between the state RAM and one bin's var_state array.
// Loads read the RAM into a holding register, then strobe the bin. Stores snapshot the bin, then write the words to RAM.
module var_state_loader #(
    parameter int NUM_VARS         = 8,
    parameter int WIDTH_VAR_STATES = 17,
    parameter int ADDR_WIDTH       = 9
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_load_i,
    input  logic                                 start_store_i,
    input  logic [ADDR_WIDTH-1:0]                base_addr_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 ram_rd_o,
    output logic                                 ram_wr_o,
    output logic [ADDR_WIDTH-1:0]                ram_addr_o,
    output logic [WIDTH_VAR_STATES-1:0]          ram_wdata_o,
    input  logic [WIDTH_VAR_STATES-1:0]          ram_rdata_i,
    output logic [NUM_VARS-1:0]                  wr_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i
);

    localparam int W     = WIDTH_VAR_STATES;
    localparam int IDX_W = $clog2(NUM_VARS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_RD,
        LOAD_WB,
        STORE,
        FINISH
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic                    pend_q;
    logic [IDX_W-1:0]        pend_idx_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    rd_q;
    logic                    wr_q;
    logic [W-1:0]            wdata_q;
    logic [NUM_VARS-1:0]     wr_states_q;
    logic [W-1:0]            hold_q [NUM_VARS];

    // Address of the next access; wraps modulo 2^ADDR_WIDTH.
    always_comb begin
        idx_d  = idx_q + IDX_W'(1);
        addr_d = base_q + ADDR_WIDTH'(idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            wr_states_q <= '0;
            // NOTE: the holding register is flops, not RAM, so it can and must be cleared on reset.
            for (int i = 0; i < NUM_VARS; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            pend_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_states_q <= '0;
            // Read data for the access issued last cycle is valid now.
            if (pend_q) begin
                hold_q[pend_idx_q] <= ram_rdata_i;
            end

            case (state_q)
                IDLE, FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                    if (start_load_i) begin
                        state_q <= LOAD_RD;
                        busy_q  <= 1'b1;
                        rd_q    <= 1'b1;
                        base_q  <= base_addr_i;
                        addr_q  <= base_addr_i;
                        idx_q   <= '0;
                    end else if (start_store_i) begin
                        state_q <= STORE;
                        busy_q  <= 1'b1;
                        wr_q    <= 1'b1;
                        base_q  <= base_addr_i;
                        addr_q  <= base_addr_i;
                        idx_q   <= '0;
                        wdata_q <= vars_states_i[W*(NUM_VARS-1) +: W];
                        for (int i = 0; i < NUM_VARS; i++) begin
                            hold_q[i] <= vars_states_i[W*(NUM_VARS-1-i) +: W];
                        end
                    end
                end

                LOAD_RD: begin
                    pend_q     <= 1'b1;
                    pend_idx_q <= idx_q;
                    if (idx_q == LAST_IDX) begin
                        state_q <= LOAD_WB;
                        rd_q    <= 1'b0;
                        addr_q  <= '0;
                    end else begin
                        idx_q  <= idx_d;
                        addr_q <= addr_d;
                    end
                end

                LOAD_WB: begin
                    state_q     <= FINISH;
                    done_q      <= 1'b1;
                    wr_states_q <= '1;
                end

                STORE: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= FINISH;
                        wr_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_d;
                        addr_q  <= addr_d;
                        wdata_q <= hold_q[idx_d];
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Variable 0 sits in the most-significant slice.
    for (genvar g = 0; g < NUM_VARS; g++) begin : g_pack
        assign vars_states_o[W*(NUM_VARS-1-g) +: W] = hold_q[g];
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ram_rd_o    = rd_q;
    assign ram_wr_o    = wr_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign wr_states_o = wr_states_q;

endmodule

// File: tb/tb_var_state_loader.sv
// Bench for var_state_loader: a per-cycle schedule model derived from the transfer timing rules,
// compared every cycle, plus directed vectors with hand-computed literal expectations.
module tb_var_state_loader;

    localparam int N    = 4;
    localparam int W    = 17;
    localparam int AW   = 9;
    localparam int MAXC = 1024;

    logic              clk;
    logic              rst;
    logic              start_load_i;
    logic              start_store_i;
    logic [AW-1:0]     base_addr_i;
    logic              busy_o;
    logic              done_o;
    logic              ram_rd_o;
    logic              ram_wr_o;
    logic [AW-1:0]     ram_addr_o;
    logic [W-1:0]      ram_wdata_o;
    logic [W-1:0]      ram_rdata_i;
    logic [N-1:0]      wr_states_o;
    logic [W*N-1:0]    vars_states_o;
    logic [W*N-1:0]    vars_states_i;

    var_state_loader #(
        .NUM_VARS(N),
        .WIDTH_VAR_STATES(W),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_load_i(start_load_i),
        .start_store_i(start_store_i),
        .base_addr_i(base_addr_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .ram_rd_o(ram_rd_o),
        .ram_wr_o(ram_wr_o),
        .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i),
        .wr_states_o(wr_states_o),
        .vars_states_o(vars_states_o),
        .vars_states_i(vars_states_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // State RAM: read data appears one cycle after ram_rd_o, garbage otherwise.
    logic [W-1:0] ram [1 << AW];
    always @(posedge clk) begin
        if (ram_rd_o) ram_rdata_i <= ram[ram_addr_o];
        else          ram_rdata_i <= W'($urandom);
    end

    // Model: on each accepted start, write down what every later cycle must show.
    // Cycle c is the interval ended by rising edge c; a start seen at edge T acts from cycle T+1.
    bit            exp_rd    [MAXC];
    bit            exp_wr    [MAXC];
    bit            exp_busy  [MAXC];
    bit            exp_done  [MAXC];
    bit            exp_wrs   [MAXC];
    logic [AW-1:0] exp_addr  [MAXC];
    logic [W-1:0]  exp_wdata [MAXC];
    bit   [N-1:0]  upd_mask  [MAXC];
    logic [W-1:0]  upd_val   [MAXC][N];
    logic [W-1:0]  hold_m    [N];
    int            op_end = 0;

    initial begin
        for (int k = 0; k < N; k++) hold_m[k] = '0;
        forever begin
            int t;
            logic [AW-1:0] a;
            @(posedge clk);
            t = cyc;
            if (rst) begin
                for (int c = t + 1; c < MAXC; c++) begin
                    exp_rd[c] = 0; exp_wr[c] = 0; exp_busy[c] = 0;
                    exp_done[c] = 0; exp_wrs[c] = 0; upd_mask[c] = '0;
                end
                for (int k = 0; k < N; k++) hold_m[k] = '0;
                op_end = t;
            end else if (op_end <= t && start_load_i) begin
                for (int k = 0; k < N; k++) begin
                    a = base_addr_i + AW'(k);
                    exp_rd[t+1+k]      = 1;
                    exp_addr[t+1+k]    = a;
                    upd_mask[t+3+k][k] = 1'b1;
                    upd_val[t+3+k][k]  = ram[a];
                end
                for (int c = t + 1; c <= t + N + 2; c++) exp_busy[c] = 1;
                exp_done[t+N+2] = 1;
                exp_wrs[t+N+2]  = 1;
                op_end = t + N + 2;
            end else if (op_end <= t && start_store_i) begin
                for (int k = 0; k < N; k++) begin
                    exp_wr[t+1+k]    = 1;
                    exp_addr[t+1+k]  = base_addr_i + AW'(k);
                    exp_wdata[t+1+k] = vars_states_i[W*(N-1-k) +: W];
                    upd_mask[t+1][k] = 1'b1;
                    upd_val[t+1][k]  = vars_states_i[W*(N-1-k) +: W];
                end
                for (int c = t + 1; c <= t + N + 1; c++) exp_busy[c] = 1;
                exp_done[t+N+1] = 1;
                op_end = t + N + 1;
            end
            cyc = t + 1;
            for (int k = 0; k < N; k++) begin
                if (upd_mask[cyc][k]) hold_m[k] = upd_val[cyc][k];
            end
        end
    end

    function automatic logic [W*N-1:0] model_vars();
        logic [W*N-1:0] v;
        for (int k = 0; k < N; k++) v[W*(N-1-k) +: W] = hold_m[k];
        return v;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy_o", 128'(busy_o), 128'(exp_busy[cyc]));
                check("done_o", 128'(done_o), 128'(exp_done[cyc]));
                check("ram_rd_o", 128'(ram_rd_o), 128'(exp_rd[cyc]));
                check("ram_wr_o", 128'(ram_wr_o), 128'(exp_wr[cyc]));
                check("wr_states_o", 128'(wr_states_o), exp_wrs[cyc] ? 128'({N{1'b1}}) : 128'(0));
                check("vars_states_o", 128'(vars_states_o), 128'(model_vars()));
                if (exp_rd[cyc] || exp_wr[cyc])
                    check("ram_addr_o", 128'(ram_addr_o), 128'(exp_addr[cyc]));
                if (exp_wr[cyc])
                    check("ram_wdata_o", 128'(ram_wdata_o), 128'(exp_wdata[cyc]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    logic [W-1:0]  store_exp [N];
    logic [AW-1:0] wrap_addr [N];
    logic [W*N-1:0] basic_vars;
    logic [W*N-1:0] store_pat2;
    int t0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = W'(i * 37 + 11);
        ram[9'h010] = 17'h00001;
        ram[9'h011] = 17'h00002;
        ram[9'h012] = 17'h00003;
        ram[9'h013] = 17'h00004;
        store_exp[0] = 17'h1FFFF; store_exp[1] = 17'h0AAAA;
        store_exp[2] = 17'h15555; store_exp[3] = 17'h00000;
        wrap_addr[0] = 9'h1FE; wrap_addr[1] = 9'h1FF;
        wrap_addr[2] = 9'h000; wrap_addr[3] = 9'h001;
        basic_vars = {17'h00001, 17'h00002, 17'h00003, 17'h00004};
        store_pat2 = {17'h12345, 17'h00F0F, 17'h1C3C3, 17'h00777};

        // Reset held for two edges with a store request pending.
        rst = 1'b1; start_load_i = 1'b0; start_store_i = 1'b1;
        base_addr_i = 9'h040; vars_states_i = {N{17'h1ABCD}};
        chk_en = 1'b1;
        tick();
        check("rst busy_o", 128'(busy_o), 128'(0));
        check("rst vars_states_o", 128'(vars_states_o), 128'(0));
        tick();
        check("rst ram_wr_o", 128'(ram_wr_o), 128'(0));
        check("rst ram_addr_o", 128'(ram_addr_o), 128'(0));
        check("rst wr_states_o", 128'(wr_states_o), 128'(0));
        rst = 1'b0; start_store_i = 1'b0;
        tick();

        // Basic load from 0x10.
        t0 = cyc; base_addr_i = 9'h010; start_load_i = 1'b1;
        tick(); start_load_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("load rd", 128'(ram_rd_o), 128'(1));
            check("load addr", 128'(ram_addr_o), 128'(9'h010 + k));
            tick();
        end
        tick();
        check("load latency", 128'(cyc - t0), 128'(6));
        check("load vars", 128'(vars_states_o), 128'(basic_vars));
        check("load wr_states", 128'(wr_states_o), 128'(4'b1111));
        check("load done", 128'(done_o), 128'(1));
        tick();
        check("load idle busy", 128'(busy_o), 128'(0));

        // Store to 0x20; the bin bus changes right after the start.
        t0 = cyc; base_addr_i = 9'h020; start_store_i = 1'b1;
        vars_states_i = {17'h1FFFF, 17'h0AAAA, 17'h15555, 17'h00000};
        tick(); start_store_i = 1'b0; vars_states_i = '0;
        for (int k = 0; k < N; k++) begin
            check("store wr", 128'(ram_wr_o), 128'(1));
            check("store addr", 128'(ram_addr_o), 128'(9'h020 + k));
            check("store wdata", 128'(ram_wdata_o), 128'(store_exp[k]));
            tick();
        end
        check("store done", 128'(done_o), 128'(1));
        tick();

        // Simultaneous start with a wrapping base: only the load runs.
        t0 = cyc; base_addr_i = 9'h1FE; start_load_i = 1'b1; start_store_i = 1'b1;
        tick(); start_load_i = 1'b0; start_store_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            check("wrap addr", 128'(ram_addr_o), 128'(wrap_addr[k]));
            check("wrap no wr", 128'(ram_wr_o), 128'(0));
            tick();
        end
        tick();
        check("wrap done", 128'(done_o), 128'(1));
        check("wrap vars", 128'(vars_states_o),
              128'({ram[9'h1FE], ram[9'h1FF], ram[9'h000], ram[9'h001]}));
        tick();

        // Store while busy is dropped; store in the done cycle starts at once.
        t0 = cyc; base_addr_i = 9'h030; start_load_i = 1'b1;
        tick(); start_load_i = 1'b0;
        tick(); start_store_i = 1'b1; base_addr_i = 9'h050;
        tick(); start_store_i = 1'b0;
        check("busy ignore wr", 128'(ram_wr_o), 128'(0));
        tick(); tick(); tick();
        check("b2b load done", 128'(done_o), 128'(1));
        start_store_i = 1'b1; base_addr_i = 9'h060; vars_states_i = store_pat2;
        tick(); start_store_i = 1'b0;
        check("b2b first wr", 128'(ram_wr_o), 128'(1));
        check("b2b first addr", 128'(ram_addr_o), 128'(9'h060));
        check("b2b first wdata", 128'(ram_wdata_o), 128'(17'h12345));
        check("b2b busy", 128'(busy_o), 128'(1));
        tick(); tick(); tick(); tick();
        check("b2b store done", 128'(done_o), 128'(1));
        tick();

        // Reset in the middle of a load, then a clean load.
        t0 = cyc; base_addr_i = 9'h010; start_load_i = 1'b1;
        tick(); start_load_i = 1'b0;
        tick();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        check("midrst busy", 128'(busy_o), 128'(0));
        check("midrst vars", 128'(vars_states_o), 128'(0));
        for (int k = 0; k < 4; k++) begin
            check("midrst no done", 128'(done_o), 128'(0));
            check("midrst no wr_states", 128'(wr_states_o), 128'(0));
            check("midrst no rd", 128'(ram_rd_o), 128'(0));
            tick();
        end
        t0 = cyc; start_load_i = 1'b1;
        tick(); start_load_i = 1'b0;
        repeat (5) tick();
        check("reload vars", 128'(vars_states_o), 128'(basic_vars));
        check("reload done", 128'(done_o), 128'(1));
        check("reload wr_states", 128'(wr_states_o), 128'(4'b1111));
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
